// File: rtl/sb_cfg_pkg.sv
// Shared definitions for the switch-box configuration loader.
//   - state_e        : loader FSM state encoding
//   - sel_e          : 2-bit per-output field codes inside a track byte
//   - BITS_PER_TRACK : config bits per track (one byte)
//   - byte_has_bad   : true when any of the four fields in a byte is SEL_BAD
package sb_cfg_pkg;

    localparam int unsigned BITS_PER_TRACK = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SEL_0   = 2'd0,
        SEL_1   = 2'd1,
        SEL_2   = 2'd2,
        SEL_BAD = 2'd3
    } sel_e;

    // Fields in {W,S,N,E} order: [7:6],[5:4],[3:2],[1:0].
    function automatic logic byte_has_bad(input logic [BITS_PER_TRACK-1:0] b);
        return (b[7:6] == SEL_BAD) || (b[5:4] == SEL_BAD) ||
               (b[3:2] == SEL_BAD) || (b[1:0] == SEL_BAD);
    endfunction

endpackage

// File: rtl/switch_box_config_loader_if.sv
// Host-to-loader config byte stream (valid/ready handshake).
//   cfg_valid : host byte valid          (master -> slave)
//   cfg_data  : track config byte        (master -> slave)
//   cfg_ready : loader accepts this cycle (slave -> master)
interface switch_box_config_loader_if;
    import sb_cfg_pkg::*;

    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [BITS_PER_TRACK-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_data, input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_data, output cfg_ready);

endinterface

// File: rtl/sb_cfg_frame_assembler.sv
// Collects W track bytes into a shadow frame and flags illegal fields.
//   clk, rst    : clock, asynchronous active-low reset
//   clear       : discard partial frame (shadow and byte_cnt to 0)
//   accept      : a byte handshake completes this cycle
//   data        : incoming track byte, written to shadow[8k+7:8k] for byte k
//   frame_next  : shadow contents after this cycle's write (full frame on last byte)
//   last_byte   : byte_cnt is at W-1
//   frame_bad   : some field of frame_next is SEL_BAD
module sb_cfg_frame_assembler
    import sb_cfg_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        accept,
    input  logic [BITS_PER_TRACK-1:0]   data,
    output logic [W*BITS_PER_TRACK-1:0] frame_next,
    output logic                        last_byte,
    output logic                        frame_bad
);

    localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

    logic [W*BITS_PER_TRACK-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]            byte_cnt_q, byte_cnt_d;

    assign last_byte  = (byte_cnt_q == CNT_W'(W - 1));
    assign frame_next = shadow_d;

    always_comb begin
        shadow_d   = shadow_q;
        byte_cnt_d = byte_cnt_q;
        if (clear) begin
            shadow_d   = '0;
            byte_cnt_d = '0;
        end else if (accept) begin
            for (int unsigned k = 0; k < W; k++) begin
                if (byte_cnt_q == CNT_W'(k)) begin
                    shadow_d[k*BITS_PER_TRACK +: BITS_PER_TRACK] = data;
                end
            end
            byte_cnt_d = last_byte ? '0 : byte_cnt_q + 1'b1;
        end
    end

    // Checked on the post-write frame so the byte arriving with the last
    // handshake is included in the legality decision.
    always_comb begin
        frame_bad = 1'b0;
        for (int unsigned k = 0; k < W; k++) begin
            if (byte_has_bad(shadow_d[k*BITS_PER_TRACK +: BITS_PER_TRACK])) begin
                frame_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q   <= '0;
            byte_cnt_q <= '0;
        end else begin
            shadow_q   <= shadow_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

endmodule

// File: rtl/switch_box_config_loader.sv
// Loads W-byte config frames for NB switch boxes over a shared bus.
//   clk, rst : clock, asynchronous active-low reset
//   start    : begin loading all NB boxes (honoured in IDLE and ERROR)
//   abort    : return to IDLE next edge, discarding the partial frame
//   cfg      : host byte stream (slave side of the valid/ready interface)
//   c        : registered shared config bus, last committed frame
//   cset     : one-hot per-box write strobe, high only in COMMIT
//   busy     : FSM not in IDLE
//   done     : one-cycle pulse after the last box commits
//   err      : sticky illegal-field flag, cleared by start
module switch_box_config_loader
    import sb_cfg_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned NB = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    switch_box_config_loader_if.slave   cfg,
    output logic [W*BITS_PER_TRACK-1:0] c,
    output logic [NB-1:0]               cset,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int unsigned BOX_W = (NB > 1) ? $clog2(NB) : 1;

    state_e                      state_q, state_d;
    logic [BOX_W-1:0]            box_cnt_q, box_cnt_d;
    logic [W*BITS_PER_TRACK-1:0] c_q, c_d;
    logic [NB-1:0]               cset_q, cset_d;
    logic                        err_q, err_d;

    logic                        accept;
    logic                        clear;
    logic [W*BITS_PER_TRACK-1:0] frame_next;
    logic                        last_byte;
    logic                        frame_bad;

    // abort overrides a handshake so a byte offered alongside it is dropped.
    assign accept = (state_q == ST_LOAD) && cfg.cfg_valid && !abort;
    assign clear  = abort || (start && ((state_q == ST_IDLE) || (state_q == ST_ERROR)));

    sb_cfg_frame_assembler #(
        .W (W)
    ) u_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .accept     (accept),
        .data       (cfg.cfg_data),
        .frame_next (frame_next),
        .last_byte  (last_byte),
        .frame_bad  (frame_bad)
    );

    // c and cset are loaded on the LOAD->COMMIT transition so both are
    // visible during the COMMIT cycle, one cycle after the last handshake.
    always_comb begin
        state_d   = state_q;
        box_cnt_d = box_cnt_q;
        c_d       = c_q;
        cset_d    = '0;
        err_d     = err_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        box_cnt_d = '0;
                        err_d     = 1'b0;
                        state_d   = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept && last_byte) begin
                        if (frame_bad) begin
                            err_d   = 1'b1;
                            state_d = ST_ERROR;
                        end else begin
                            c_d     = frame_next;
                            cset_d  = NB'(1) << box_cnt_q;
                            state_d = ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (box_cnt_q == BOX_W'(NB - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        box_cnt_d = box_cnt_q + 1'b1;
                        state_d   = ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                ST_ERROR: begin
                    if (start) begin
                        box_cnt_d = '0;
                        err_d     = 1'b0;
                        state_d   = ST_LOAD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            box_cnt_q <= '0;
            c_q       <= '0;
            cset_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            box_cnt_q <= box_cnt_d;
            c_q       <= c_d;
            cset_q    <= cset_d;
            err_q     <= err_d;
        end
    end

    assign c             = c_q;
    assign cset          = cset_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign err           = err_q;
    assign cfg.cfg_ready = (state_q == ST_LOAD);

endmodule

// File: tb/tb_switch_box_config_loader.sv
module tb_switch_box_config_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [63:0] c;
    logic [3:0]  cset;
    logic        busy;
    logic        done;
    logic        err;

    switch_box_config_loader_if ifc ();

    switch_box_config_loader #(
        .W  (8),
        .NB (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .cfg   (ifc),
        .c     (c),
        .cset  (cset),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  stim [32];
    logic [63:0] frames [4];
    logic [63:0] last_c;
    int          acc_total;
    int          box;
    int          bad_box;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_frames();
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 8; k++)
                frames[b][k*8 +: 8] = stim[b*8 + k];
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < 32; i++) stim[i] = v;
    endtask

    task automatic fill_distinct();
        for (int i = 0; i < 32; i++)
            stim[i] = {2'(i % 3), 2'((i / 3) % 3), 2'((i / 9) % 3), 2'(i % 2)};
    endtask

    task automatic begin_load(input int bad);
        acc_total = 0;
        box       = 0;
        bad_box   = bad;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_ready", 64'(ifc.cfg_ready), 64'd1);
        check("start_err_clr", 64'(err), 64'd0);
    endtask

    // Offers n bytes; after each handshake that completes a frame the
    // commit (or the error entry for bad_box) must be visible immediately.
    task automatic drive_bytes(input int n, input bit toggle);
        int   sent = 0;
        int   cyc  = 0;
        logic v;
        logic rdy;
        while (sent < n && cyc < 1000) begin
            v             = toggle ? (cyc % 2 == 0) : 1'b1;
            ifc.cfg_valid = v;
            ifc.cfg_data  = stim[acc_total];
            rdy           = ifc.cfg_ready;
            tick();
            cyc++;
            if (v && rdy) begin
                sent++;
                acc_total++;
                if (acc_total % 8 == 0) begin
                    if (box == bad_box) begin
                        check("err_set", 64'(err), 64'd1);
                        check("err_no_cset", 64'(cset), 64'd0);
                        check("err_ready", 64'(ifc.cfg_ready), 64'd0);
                        check("err_c_hold", c, last_c);
                    end else begin
                        check("cset_commit", 64'(cset), 64'd1 << box);
                        check("c_commit", c, frames[box]);
                        last_c = frames[box];
                    end
                    box++;
                end else begin
                    check("cset_quiet", 64'(cset), 64'd0);
                end
            end else begin
                check("cset_quiet", 64'(cset), 64'd0);
            end
        end
        ifc.cfg_valid = 1'b0;
        check("drive_timeout", 64'(sent), 64'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_c"}, c, 64'd0);
        check({tag, "_cset"}, 64'(cset), 64'd0);
        check({tag, "_ready"}, 64'(ifc.cfg_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        ifc.cfg_valid = 1'b0;
        ifc.cfg_data  = 8'h00;
        last_c        = 64'd0;

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            start         = 1'($urandom);
            abort         = 1'($urandom);
            ifc.cfg_valid = 1'($urandom);
            ifc.cfg_data  = 8'($urandom);
            tick();
            check_all_zero("reset");
        end
        start         = 1'b0;
        abort         = 1'b0;
        ifc.cfg_valid = 1'b0;
        rst           = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        // Full load, valid held high.
        fill_const(8'h24);
        build_frames();
        pulse_start();
        begin_load(-1);
        drive_bytes(32, 1'b0);
        check("full_c", c, 64'h2424242424242424);
        tick();
        check("full_done", 64'(done), 64'd1);
        check("full_done_cset", 64'(cset), 64'd0);
        tick();
        check("full_done_pulse", 64'(done), 64'd0);
        check("full_idle", 64'(busy), 64'd0);

        // Backpressure with distinct bytes per track.
        fill_distinct();
        build_frames();
        pulse_start();
        begin_load(-1);
        drive_bytes(32, 1'b1);
        tick();
        check("bp_done", 64'(done), 64'd1);
        tick();
        check("bp_idle", 64'(busy), 64'd0);

        // Illegal field: box 1 track 5 = 0x03.
        fill_const(8'h24);
        stim[13] = 8'h03;
        build_frames();
        pulse_start();
        begin_load(1);
        drive_bytes(16, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err_stay_cset", 64'(cset), 64'd0);
            check("err_stay_busy", 64'(busy), 64'd1);
            check("err_stay_c", c, 64'h2424242424242424);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("err_abort_idle", 64'(busy), 64'd0);
        check("err_abort_kept", 64'(err), 64'd1);

        // Illegal field carried only by the last byte of a frame.
        fill_const(8'h24);
        stim[7] = 8'hC0;
        build_frames();
        pulse_start();
        begin_load(0);
        drive_bytes(8, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_restart_err", 64'(err), 64'd0);
        check("err_restart_ready", 64'(ifc.cfg_ready), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", 64'(busy), 64'd0);

        // start held through the load, then abort+start in box 2.
        fill_distinct();
        build_frames();
        pulse_start();
        begin_load(-1);
        start = 1'b1;
        drive_bytes(19, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cset", 64'(cset), 64'd0);
        check("abort_ready", 64'(ifc.cfg_ready), 64'd0);
        check("abort_c_hold", c, frames[1]);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_quiet", 64'(cset), 64'd0);
        end
        pulse_start();
        begin_load(-1);
        drive_bytes(32, 1'b0);
        tick();
        check("reload_done", 64'(done), 64'd1);
        tick();

        // Asynchronous reset after 5 bytes of box 0.
        fill_const(8'h24);
        build_frames();
        pulse_start();
        begin_load(-1);
        drive_bytes(5, 1'b0);
        ifc.cfg_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_rst_cset", 64'(cset), 64'd0);
            check("post_rst_busy", 64'(busy), 64'd0);
        end
        ifc.cfg_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
